seg_display_scanner: RTL and testbench
======================================

SEG_DISPLAY_SCANNER -- requirements
Module: seg_display_scanner

Interface
REQ-001 Parameter DIV, default 50000: clock cycles per digit slot; legal range DIV >= 2.
REQ-002 Parameter SEG_ACTIVE_LOW, default 1: 1 means a lit segment is driven 0 on seg; 0 means a lit segment is driven 1.
REQ-003 Port clk, input, 1 bit: the block's single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Ports display0..display5, input, 7 bits each: segment pattern per digit, bit=1 means segment lit, display0 is the rightmost digit.
REQ-006 Port blank, input, 1 bit: 1 forces all digits dark.
REQ-007 Port digit_en, input, 6 bits: bit k=0 keeps digit k dark during its slot.
REQ-008 Port seg, output, 7 bits, registered: segment drive for the currently selected digit.
REQ-009 Port an, output, 6 bits, registered: active-low, one-hot digit select; all ones means no digit selected.
REQ-010 Port frame_tick, output, 1 bit, registered: one-cycle pulse at each frame boundary.

Function
REQ-011 The prescaler SHALL count 0..DIV-1 and wrap to 0; a "slot end" is any cycle in which the prescaler equals DIV-1.
REQ-012 The digit index (0..5) SHALL advance by 1 at each slot end, wrapping from 5 to 0.
REQ-013 A frame boundary is a slot end with index==5.
  - On that edge the six shadow registers SHALL load display0..display5.
  - On that same edge frame_tick SHALL be set to 1; frame_tick is 0 on every other cycle.
REQ-014 Changes on display0..display5 between frame boundaries SHALL have no effect on seg.
REQ-015 an and seg SHALL be registered from the current index and shadow registers, so both lag an index change by exactly 1 cycle.
REQ-016 Digit dark condition: dark = blank OR (digit_en[index]==0).
  - When not dark: an = ~(6'b1 << index); seg = shadow[index], inverted when SEG_ACTIVE_LOW=1.
  - When dark: an = 6'b111111; seg = all segments off (7'h7F if SEG_ACTIVE_LOW=1, 7'h00 otherwise).
REQ-017 blank and digit_en SHALL be sampled every cycle.
  - Neither SHALL stall or reset the prescaler, the index, or the frame_tick cadence.
  - Deasserting blank resumes display at whichever digit the index currently holds.
REQ-018 frame_tick SHALL pulse once every 6*DIV cycles, with no jitter.
REQ-019 No state SHALL depend on input values other than as stated in REQ-013 and REQ-016; no combinational path SHALL exist from any input to any output.

Reset
REQ-020 While rst_n=0, independent of clk, the block SHALL hold:
  - prescaler = 0, index = 0, all shadow registers = 7'h00;
  - an = 6'b111111, seg = segments off, frame_tick = 0.
REQ-021 Asserting rst_n mid-slot or mid-frame SHALL force the REQ-020 values immediately.
  - After release, counting restarts from prescaler 0, index 0.
  - Shadow registers stay 0, so all digits show blank patterns until the first frame boundary.
REQ-022 The first frame_tick after reset release SHALL occur on rising edge 6*DIV, counting the first edge after release as edge 1.

Verification (DIV=4, SEG_ACTIVE_LOW=1, blank=0, digit_en=6'b111111 unless stated)
REQ-023 Hold rst_n=0 and toggle clk -> an=6'b111111, seg=7'h7F, frame_tick=0 throughout.
REQ-024 Set display0=7'h3F and display1=7'h06, then release reset:
  - frame_tick=1 only on edge 24;
  - after that edge, slots of 4 cycles each show an=6'b111110 with seg=7'h40, then an=6'b111101 with seg=7'h79.
REQ-025 Change display2 from 7'h5B to 7'h4F after the first frame_tick, mid-frame:
  - the digit-2 slot still shows seg=7'h24;
  - the next frame's digit-2 slot shows seg=7'h30.
REQ-026 Assert blank=1 for 10 cycles mid-frame:
  - an=6'b111111 and seg=7'h7F starting one cycle later;
  - frame_tick still pulses at 24-cycle spacing;
  - after release, an matches the index-derived value within 1 cycle.
REQ-027 Set digit_en=6'b111011 -> during the digit-2 slot an=6'b111111 and seg=7'h7F; all other slots are unchanged.
REQ-028 Pull rst_n low 2 cycles after a frame_tick, between clock edges:
  - outputs go to the REQ-020 values without waiting for a clock edge;
  - after release, the next frame_tick occurs on edge 24.

Source files
------------

// File: rtl/seg_display_scanner_if.sv
// rtl/seg_display_scanner_if.sv - digit data in, multiplexed segment/anode drive out
interface seg_display_scanner_if;
   logic [6:0] display0;
   logic [6:0] display1;
   logic [6:0] display2;
   logic [6:0] display3;
   logic [6:0] display4;
   logic [6:0] display5;
   logic       blank;
   logic [5:0] digit_en;
   logic [6:0] seg;
   logic [5:0] an;
   logic       frame_tick;

   // Source of digit patterns and controls, consumer of the panel drive
   modport master (
      output display0, display1, display2, display3, display4, display5,
      output blank, digit_en,
      input  seg, an, frame_tick
   );

   // The scanner itself
   modport slave (
      input  display0, display1, display2, display3, display4, display5,
      input  blank, digit_en,
      output seg, an, frame_tick
   );
endinterface

// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - six-digit seven-segment multiplex scanner with frame-latched shadows
module seg_display_scanner #(
   parameter int DIV            = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input logic                  clk,
   input logic                  rst_n,
   seg_display_scanner_if.slave bus
);

   localparam int             LP_PW        = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [LP_PW-1:0] LP_PRESC_LAST = LP_PW'(DIV - 1);
   localparam logic [6:0]     LP_SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [5:0]     LP_AN_NONE   = 6'b111111;

   logic [LP_PW-1:0] r_presc;
   logic [2:0]       r_idx;
   logic [6:0]       r_shadow [0:5];
   logic [6:0]       r_seg;
   logic [5:0]       r_an;
   logic             r_frame_tick;

   logic             w_slot_end;
   logic             w_frame_end;
   logic             w_dark;
   logic [6:0]       w_lit;
   logic [6:0]       w_seg_nxt;
   logic [5:0]       w_an_nxt;

   assign w_slot_end  = (r_presc == LP_PRESC_LAST);
   assign w_frame_end = w_slot_end && (r_idx == 3'd5);

   // Drive for the digit the index currently points at; blank/digit_en only gate the outputs
   always_comb begin
      w_dark    = bus.blank | ~bus.digit_en[r_idx];
      w_lit     = r_shadow[r_idx];
      w_seg_nxt = LP_SEG_OFF;
      w_an_nxt  = LP_AN_NONE;
      if (!w_dark) begin
         w_seg_nxt = SEG_ACTIVE_LOW ? ~w_lit : w_lit;
         w_an_nxt  = ~(6'b000001 << r_idx);
      end
   end

   // Slot prescaler and digit index; free-running so blanking never disturbs the cadence
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
         r_idx   <= 3'd0;
      end else begin
         r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
         if (w_slot_end) begin
            r_idx <= (r_idx == 3'd5) ? 3'd0 : r_idx + 3'd1;
         end
      end
   end

   // Shadow copies of the digit patterns, refreshed only at frame boundaries so a frame is never torn
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 6; k++) begin
            r_shadow[k] <= 7'h00;
         end
      end else if (w_frame_end) begin
         r_shadow[0] <= bus.display0;
         r_shadow[1] <= bus.display1;
         r_shadow[2] <= bus.display2;
         r_shadow[3] <= bus.display3;
         r_shadow[4] <= bus.display4;
         r_shadow[5] <= bus.display5;
      end
   end

   // Registered panel drive and frame pulse; outputs trail the index by one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg        <= LP_SEG_OFF;
         r_an         <= LP_AN_NONE;
         r_frame_tick <= 1'b0;
      end else begin
         r_seg        <= w_seg_nxt;
         r_an         <= w_an_nxt;
         r_frame_tick <= w_frame_end;
      end
   end

   assign bus.seg        = r_seg;
   assign bus.an         = r_an;
   assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_display_scanner.sv
// tb/tb_seg_display_scanner.sv - scoreboard bench for seg_display_scanner with a time-based reference model
module tb_seg_display_scanner;

   localparam int DIV   = 4;
   localparam int FRAME = 6 * DIV;

   typedef struct {
      int         edge_no;
      logic [5:0] an;
      logic [6:0] seg;
      logic       ft;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   int   n;
   exp_t q[$];
   logic [6:0] m_shadow [0:5];

   seg_display_scanner_if u_if ();

   seg_display_scanner #(
      .DIV            (DIV),
      .SEG_ACTIVE_LOW (1'b1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at edge %0d: actual %0h required %0h", name, n, act, req);
      end
   endtask

   function automatic logic [6:0] disp(input int k);
      case (k)
         0:       return u_if.display0;
         1:       return u_if.display1;
         2:       return u_if.display2;
         3:       return u_if.display3;
         4:       return u_if.display4;
         default: return u_if.display5;
      endcase
   endfunction

   task automatic rand_displays();
      u_if.display0 = 7'($urandom);
      u_if.display1 = 7'($urandom);
      u_if.display2 = 7'($urandom);
      u_if.display3 = 7'($urandom);
      u_if.display4 = 7'($urandom);
      u_if.display5 = 7'($urandom);
   endtask

   // Reference: outputs after edge n follow the digit slot that edge n closes out,
   // the patterns latched at the last frame boundary, and the controls present at that edge
   task automatic step();
      int         idx;
      logic       dark;
      logic [5:0] one;
      exp_t       e;
      n++;
      one  = 6'b000001;
      idx  = ((n - 1) / DIV) % 6;
      dark = u_if.blank || !u_if.digit_en[idx];
      e.edge_no = n;
      e.an      = dark ? 6'h3F : ~(one << idx);
      e.seg     = dark ? 7'h7F : ~m_shadow[idx];
      e.ft      = ((n % FRAME) == 0);
      q.push_back(e);
      if (e.ft) begin
         for (int k = 0; k < 6; k++) m_shadow[k] = disp(k);
      end
   endtask

   task automatic model_reset();
      n = 0;
      for (int k = 0; k < 6; k++) m_shadow[k] = 7'h00;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_an"},  int'(u_if.an), 'h3F);
      chk({tag, "_seg"}, int'(u_if.seg), 'h7F);
      chk({tag, "_ft"},  int'(u_if.frame_tick), 0);
   endtask

   // Inputs for the edge about to come (edge number e)
   task automatic drive_inputs(input int e);
      if (e <= 60) begin
         u_if.display0 = 7'h3F;
         u_if.display1 = 7'h06;
         u_if.display2 = (e <= 30) ? 7'h5B : 7'h4F;
         u_if.display3 = 7'h66;
         u_if.display4 = 7'h6D;
         u_if.display5 = 7'h7D;
      end else begin
         rand_displays();
      end
      u_if.blank = (e >= 70 && e < 80);
      if (e >= 90 && e < 140) u_if.digit_en = 6'b111011;
      else if (e < 150)       u_if.digit_en = 6'b111111;
      if (e >= 150) begin
         u_if.blank = ($urandom_range(9) == 0);
         if ((e % 5) == 0) u_if.digit_en = 6'($urandom);
      end
   endtask

   // Monitor: every edge with a pending expectation is compared just after it
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (u_if.an !== e.an || u_if.seg !== e.seg || u_if.frame_tick !== e.ft) begin
            errors++;
            $display("FAIL scoreboard edge %0d: actual an=%b seg=%h ft=%b required an=%b seg=%h ft=%b",
                     e.edge_no, u_if.an, u_if.seg, u_if.frame_tick, e.an, e.seg, e.ft);
         end
      end
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      u_if.blank    = 1'b0;
      u_if.digit_en = 6'b111111;
      rand_displays();
      model_reset();

      // Reset held with clock running
      repeat (4) begin
         @(negedge clk);
         chk_reset_vals("reset_hold");
         rand_displays();
      end

      // Release and run the directed + random sequence
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      drive_inputs(1);
      step();
      while (n < 400 || (n % FRAME) != 2) begin
         @(negedge clk);
         if (n == 23) chk("ft_before_24", int'(u_if.frame_tick), 0);
         if (n == 24) chk("ft_edge_24", int'(u_if.frame_tick), 1);
         if (n == 25) begin
            chk("d0_an", int'(u_if.an), 'h3E);
            chk("d0_seg", int'(u_if.seg), 'h40);
         end
         if (n == 29) begin
            chk("d1_an", int'(u_if.an), 'h3D);
            chk("d1_seg", int'(u_if.seg), 'h79);
         end
         if (n == 34) chk("d2_old_seg", int'(u_if.seg), 'h24);
         if (n == 58) chk("d2_new_seg", int'(u_if.seg), 'h30);
         if (n == 70) chk("blank_an", int'(u_if.an), 'h3F);
         if (n == 72) chk("blank_ft", int'(u_if.frame_tick), 1);
         if (n == 81) chk("unblank_an", int'(u_if.an), 'h3B);
         if (n == 106) begin
            chk("den_off_an", int'(u_if.an), 'h3F);
            chk("den_off_seg", int'(u_if.seg), 'h7F);
         end
         if (n == 110) chk("den_d3_an", int'(u_if.an), 'h37);
         drive_inputs(n + 1);
         step();
      end

      // Asynchronous reset two cycles after a frame tick, between edges
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async_rst");
      u_if.blank    = 1'b0;
      u_if.digit_en = 6'b111111;
      repeat (3) begin
         @(negedge clk);
         chk_reset_vals("rst_again");
      end

      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      rand_displays();
      step();
      while (n < 60) begin
         @(negedge clk);
         if (n == 5) begin
            chk("post_rst_an", int'(u_if.an), 'h3D);
            chk("post_rst_seg", int'(u_if.seg), 'h7F);
         end
         if (n == 23) chk("post_rst_ft23", int'(u_if.frame_tick), 0);
         if (n == 24) chk("post_rst_ft24", int'(u_if.frame_tick), 1);
         rand_displays();
         step();
      end

      repeat (2) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
